// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor with a direct-mapped BTB.
// - Pattern table of 2-bit saturating counters, indexed by PC XOR global history.
// - BTB entries hold valid, tag, target and an is_cond flag.
// - After reset an init sweep walks every pattern-table index, one per cycle.
//   It sets each counter to weakly-not-taken and clears the BTB valid bits.
//   Lookups and updates are ignored until the sweep is done.
// - Optional statistics counters are enabled by defining BP_STATS_EN.
// Assumes BTB_IDX_BITS <= PT_IDX_BITS and BHR_BITS >= 2.
module branch_predictor_gshare #(
    parameter int unsigned DBITS        = 32,
    parameter int unsigned BHR_BITS     = 8,
    parameter int unsigned PT_IDX_BITS  = 8,
    parameter int unsigned BTB_IDX_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ready,
    // lookup
    input  logic                    lk_valid,
    input  logic [DBITS-1:0]        lk_pc,
    output logic                    pred_valid,
    output logic                    pred_btb_hit,
    output logic                    pred_taken,
    output logic [DBITS-1:0]        pred_target,
    output logic [PT_IDX_BITS-1:0]  pred_pt_idx,
    output logic [BTB_IDX_BITS-1:0] pred_btb_idx,
    // update
    input  logic                    up_valid,
    input  logic [DBITS-1:0]        up_pc,
    input  logic                    up_is_cond,
    input  logic                    up_taken,
    input  logic [DBITS-1:0]        up_target,
    input  logic [PT_IDX_BITS-1:0]  up_pt_idx,
    input  logic                    up_mispredict,
    // statistics
    output logic [31:0]             stat_branches,
    output logic [31:0]             stat_mispredicts
);

    localparam int unsigned PtEntries  = 1 << PT_IDX_BITS;
    localparam int unsigned BtbEntries = 1 << BTB_IDX_BITS;
    localparam int unsigned TagBits    = DBITS - BTB_IDX_BITS - 2;
    localparam logic [PT_IDX_BITS-1:0] SweepLast = PT_IDX_BITS'(PtEntries - 1);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                   state_q, state_d;
    logic [PT_IDX_BITS-1:0]   sweep_q, sweep_d;
    logic [BHR_BITS-1:0]      bhr_q;
    logic [PT_IDX_BITS-1:0]   bhr_ext;

    logic [1:0]               pt_mem     [PtEntries];
    logic                     btb_valid  [BtbEntries];
    logic [TagBits-1:0]       btb_tag    [BtbEntries];
    logic [DBITS-1:0]         btb_target [BtbEntries];
    logic                     btb_cond   [BtbEntries];

    logic                     lk_fire, up_fire;
    logic [PT_IDX_BITS-1:0]   lk_pt_idx;
    logic [BTB_IDX_BITS-1:0]  lk_btb_idx, up_btb_idx;
    logic [TagBits-1:0]       lk_tag, up_tag;
    logic                     lk_hit, lk_taken;
    logic [1:0]               lk_ctr, up_ctr, up_ctr_next;
    logic [DBITS-1:0]         lk_target;
    logic                     sweep_in_btb;
    logic                     unused_pc_bits;

    assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

    // History is zero-extended or truncated to the pattern-table index width.
    if (BHR_BITS >= PT_IDX_BITS) begin : g_bhr_trunc
        assign bhr_ext = bhr_q[PT_IDX_BITS-1:0];
    end else begin : g_bhr_ext
        assign bhr_ext = {{(PT_IDX_BITS - BHR_BITS){1'b0}}, bhr_q};
    end

    // Init FSM and sweep index register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Init FSM next state: one index per cycle, leave INIT after the last one.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StInit: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == SweepLast) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // Init FSM outputs.
    always_comb begin
        ready = (state_q == StReady);
    end

    // Index, tag and prediction computed from the pre-update tables.
    always_comb begin
        lk_fire      = lk_valid && ready;
        up_fire      = up_valid && ready;
        lk_pt_idx    = lk_pc[PT_IDX_BITS+1:2] ^ bhr_ext;
        lk_btb_idx   = lk_pc[BTB_IDX_BITS+1:2];
        lk_tag       = lk_pc[DBITS-1:BTB_IDX_BITS+2];
        up_btb_idx   = up_pc[BTB_IDX_BITS+1:2];
        up_tag       = up_pc[DBITS-1:BTB_IDX_BITS+2];
        lk_hit       = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
        lk_ctr       = pt_mem[lk_pt_idx];
        lk_taken     = lk_hit && (!btb_cond[lk_btb_idx] || lk_ctr[1]);
        lk_target    = lk_hit ? btb_target[lk_btb_idx] : lk_pc + DBITS'(4);
        sweep_in_btb = (32'(sweep_q) < BtbEntries);
    end

    // Saturating counter step for the update port.
    always_comb begin
        up_ctr      = pt_mem[up_pt_idx];
        up_ctr_next = up_ctr;
        if (up_taken) begin
            if (up_ctr != 2'b11) begin
                up_ctr_next = up_ctr + 2'b01;
            end
        end else begin
            if (up_ctr != 2'b00) begin
                up_ctr_next = up_ctr - 2'b01;
            end
        end
    end

    // Registered lookup result; pred_valid pulses for one cycle per accepted lookup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid   <= 1'b0;
            pred_btb_hit <= 1'b0;
            pred_taken   <= 1'b0;
            pred_target  <= '0;
            pred_pt_idx  <= '0;
            pred_btb_idx <= '0;
        end else begin
            pred_valid <= lk_fire;
            if (lk_fire) begin
                pred_btb_hit <= lk_hit;
                pred_taken   <= lk_taken;
                pred_target  <= lk_target;
                pred_pt_idx  <= lk_pt_idx;
                pred_btb_idx <= lk_btb_idx;
            end
        end
    end

    // Global history shifts in the outcome of each conditional branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bhr_q <= '0;
        end else if (up_fire && up_is_cond) begin
            bhr_q <= {bhr_q[BHR_BITS-2:0], up_taken};
        end
    end

    // Pattern table: sweep initialisation, then conditional-branch training.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            pt_mem[sweep_q] <= 2'b01;
        end else if (up_fire && up_is_cond) begin
            pt_mem[up_pt_idx] <= up_ctr_next;
        end
    end

    // BTB: sweep clears valid bits, taken updates allocate/overwrite the entry.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            if (sweep_in_btb) begin
                btb_valid[sweep_q[BTB_IDX_BITS-1:0]] <= 1'b0;
            end
        end else if (up_fire && up_taken) begin
            btb_valid[up_btb_idx]  <= 1'b1;
            btb_tag[up_btb_idx]    <= up_tag;
            btb_target[up_btb_idx] <= up_target;
            btb_cond[up_btb_idx]   <= up_is_cond;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    // Saturating counters of accepted updates and of reported mispredicts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else if (up_fire) begin
            if (branches_q != 32'hFFFF_FFFF) begin
                branches_q <= branches_q + 32'd1;
            end
            if (up_mispredict && (mispredicts_q != 32'hFFFF_FFFF)) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    logic unused_stats;

    assign unused_stats     = up_mispredict;
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare (default parameters).
// Expected lookup results are queued when a lookup is driven and checked when pred_valid rises.
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        pred_valid, pred_btb_hit, pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_pt_idx;
    logic [3:0]  pred_btb_idx;
    logic        up_valid, up_is_cond, up_taken, up_mispredict;
    logic [31:0] up_pc, up_target;
    logic [7:0]  up_pt_idx;
    logic [31:0] stat_branches, stat_mispredicts;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [7:0]  pt;
        logic [3:0]  btb;
    } pred_t;

    pred_t sb[$];
    pred_t sb_exp, sb_obs;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    exp_branches = 0;
    int    exp_mispred = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare dut (
        .clk              (clk),
        .reset            (reset),
        .ready            (ready),
        .lk_valid         (lk_valid),
        .lk_pc            (lk_pc),
        .pred_valid       (pred_valid),
        .pred_btb_hit     (pred_btb_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_pt_idx      (pred_pt_idx),
        .pred_btb_idx     (pred_btb_idx),
        .up_valid         (up_valid),
        .up_pc            (up_pc),
        .up_is_cond       (up_is_cond),
        .up_taken         (up_taken),
        .up_target        (up_target),
        .up_pt_idx        (up_pt_idx),
        .up_mispredict    (up_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    // Scoreboard: every pred_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pred_valid === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL pred_unexpected: observed pred_valid=1 required no pending lookup");
            end
            if (sb.size() != 0) begin
                sb_exp = sb.pop_front();
                sb_obs = {pred_btb_hit, pred_taken, pred_target, pred_pt_idx, pred_btb_idx};
                n_cmp++;
                assert (sb_obs === sb_exp) else begin
                    n_fail++;
                    $error("FAIL pred_result: observed hit=%0b taken=%0b tgt=%h pt=%h btb=%h required hit=%0b taken=%0b tgt=%h pt=%h btb=%h",
                           sb_obs.hit, sb_obs.taken, sb_obs.target, sb_obs.pt, sb_obs.btb,
                           sb_exp.hit, sb_exp.taken, sb_exp.target, sb_exp.pt, sb_exp.btb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed time limit reached, required bench completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
        end
    endtask

    function automatic pred_t mk(input logic hit, input logic taken, input logic [31:0] tgt,
                                 input logic [7:0] pt, input logic [3:0] btb);
        pred_t p;
        p.hit    = hit;
        p.taken  = taken;
        p.target = tgt;
        p.pt     = pt;
        p.btb    = btb;
        return p;
    endfunction

    // One lookup; its result must be consumed at the very next negedge.
    task automatic lookup(input logic [31:0] pc, input pred_t e);
        lk_valid = 1'b1;
        lk_pc    = pc;
        sb.push_back(e);
        tick();
        lk_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("pred_latency", 64'(sb.size()), 64'd0);
    endtask

    task automatic update(input logic [31:0] pc, input logic cond, input logic taken,
                          input logic [31:0] tgt, input logic [7:0] pt, input logic misp);
        up_valid      = 1'b1;
        up_pc         = pc;
        up_is_cond    = cond;
        up_taken      = taken;
        up_target     = tgt;
        up_pt_idx     = pt;
        up_mispredict = misp;
        tick();
        up_valid = 1'b0;
        exp_branches++;
        if (misp) exp_mispred++;
    endtask

    // Ready must stay low for 255 edges after release and rise on edge 256.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk(tag, 64'(ready), 64'(i == 256));
        end
    endtask

    initial begin
        reset = 1'b1;
        lk_valid = 1'b0; lk_pc = '0;
        up_valid = 1'b0; up_pc = '0; up_is_cond = 1'b0; up_taken = 1'b0;
        up_target = '0; up_pt_idx = '0; up_mispredict = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_pred_valid", 64'(pred_valid), 64'd0);
        chk("reset_stat_br", 64'(stat_branches), 64'd0);
        chk("reset_stat_mp", 64'(stat_mispredicts), 64'd0);
        reset = 1'b0;

        // Traffic during the sweep must be ignored (no pred_valid, no BTB/BHR/stat change).
        lk_valid = 1'b1; lk_pc = 32'h184;
        up_valid = 1'b1; up_pc = 32'h184; up_is_cond = 1'b1; up_taken = 1'b1;
        up_target = 32'h400; up_pt_idx = 8'h61; up_mispredict = 1'b1;
        sweep_check("sweep_ready");
        lk_valid = 1'b0;
        up_valid = 1'b0;

        lookup(32'h100, mk(1'b0, 1'b0, 32'h104, 8'h40, 4'h0));
        lookup(32'h184, mk(1'b0, 1'b0, 32'h188, 8'h61, 4'h1));

        // JAL update allocates the BTB entry and leaves history alone.
        update(32'h100, 1'b0, 1'b1, 32'h200, 8'h00, 1'b1);
        lookup(32'h100, mk(1'b1, 1'b1, 32'h200, 8'h40, 4'h0));

        // Counter at 0x10 trained by four taken updates; lookup here indexes 0x2E^0x0F=0x21.
        repeat (4) update(32'h0B8, 1'b1, 1'b1, 32'h300, 8'h10, 1'b0);
        lookup(32'h0B8, mk(1'b1, 1'b0, 32'h300, 8'h21, 4'hE));
        // Fifth taken saturates at 3, one not-taken gives 2 (still taken); BHR=0x3E.
        update(32'h1B0, 1'b1, 1'b1, 32'h340, 8'h10, 1'b0);
        update(32'h0B8, 1'b1, 1'b0, 32'h300, 8'h10, 1'b0);
        lookup(32'h0B8, mk(1'b1, 1'b1, 32'h300, 8'h10, 4'hE));
        // Another not-taken gives 1 (not taken); BHR=0x7C, 0x6C^0x7C=0x10.
        update(32'h0B8, 1'b1, 1'b0, 32'h300, 8'h10, 1'b0);
        lookup(32'h1B0, mk(1'b1, 1'b0, 32'h340, 8'h10, 4'hC));

        // 0x140 shares BTB index 0 with 0x100 and evicts it.
        update(32'h140, 1'b0, 1'b1, 32'h300, 8'h00, 1'b1);
        lookup(32'h100, mk(1'b0, 1'b0, 32'h104, 8'h3C, 4'h0));
        lookup(32'h140, mk(1'b1, 1'b1, 32'h300, 8'h2C, 4'h0));

        // Same-cycle lookup and update: the lookup sees the old table.
        lk_valid = 1'b1; lk_pc = 32'h100;
        up_valid = 1'b1; up_pc = 32'h100; up_is_cond = 1'b0; up_taken = 1'b1;
        up_target = 32'h200; up_pt_idx = 8'h00; up_mispredict = 1'b0;
        sb.push_back(mk(1'b0, 1'b0, 32'h104, 8'h3C, 4'h0));
        tick();
        lk_valid = 1'b0;
        up_valid = 1'b0;
        exp_branches++;
        @(negedge clk);
        #1;
        chk("pred_latency", 64'(sb.size()), 64'd0);
        lookup(32'h100, mk(1'b1, 1'b1, 32'h200, 8'h3C, 4'h0));

`ifdef BP_STATS_EN
        chk("stat_branches", 64'(stat_branches), 64'(exp_branches));
        chk("stat_mispredicts", 64'(stat_mispredicts), 64'(exp_mispred));
`else
        chk("stat_branches", 64'(stat_branches), 64'd0);
        chk("stat_mispredicts", 64'(stat_mispredicts), 64'd0);
`endif

        // Asynchronous reset clears outputs before any clock edge.
        tick();
        reset = 1'b1;
        #1;
        chk("areset_ready", 64'(ready), 64'd0);
        chk("areset_hit", 64'(pred_btb_hit), 64'd0);
        chk("areset_taken", 64'(pred_taken), 64'd0);
        chk("areset_target", 64'(pred_target), 64'd0);
        chk("areset_pt_idx", 64'(pred_pt_idx), 64'd0);
        chk("areset_stat_br", 64'(stat_branches), 64'd0);
        chk("areset_stat_mp", 64'(stat_mispredicts), 64'd0);
        tick();
        reset = 1'b0;

        // Reset in the middle of the sweep restarts it from index 0.
        repeat (100) tick();
        chk("midsweep_ready", 64'(ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep_check("resweep_ready");

        // Sweep cleared the BTB and history is back to zero.
        lookup(32'h100, mk(1'b0, 1'b0, 32'h104, 8'h40, 4'h0));
        lookup(32'h140, mk(1'b0, 1'b0, 32'h144, 8'h50, 4'h0));

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
